// File: rtl/cpu_cycle_ctrl_pkg.sv
// cpu_cycle_ctrl_pkg: shared types for the multi-cycle sequencer.
//   size_t    : 32-bit machine address / PC word
//   state_t   : sequencer state encoding (3 bits, exported on state_o)
//   HALT_ADDR : fetching from this address stops the core
package cpu_cycle_ctrl_pkg;

  typedef logic [31:0] size_t;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC1  = 3'd2,
    S_EXEC2  = 3'd3,
    S_HALTED = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam size_t HALT_ADDR = 32'h0;

  // Counter width able to hold 0..max_val; never narrower than one bit so a
  // disabled feature (max_val == 0) still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/cpu_stall_timer.sv
// cpu_stall_timer: counts consecutive bus stall cycles and flags a timeout.
//   in : clk, reset_n (async, active low), stall (bus access held off this cycle)
//   out: timeout (stall still pending with MAX_WAIT cycles already counted)
module cpu_stall_timer
  import cpu_cycle_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic stall,
  output logic timeout
);

  localparam int CW = cnt_width(MAX_WAIT);

  logic [CW-1:0] wait_cnt;

  // Any non-stall cycle restarts the count; the counter parks at all-ones
  // rather than wrapping so a very long stall can never look short again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (!stall) begin
      wait_cnt <= '0;
    end else if (wait_cnt != {CW{1'b1}}) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // MAX_WAIT == 0 disables the timeout entirely.
  assign timeout = (MAX_WAIT != 0) && stall && (wait_cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/cpu_cycle_ctrl.sv
// cpu_cycle_ctrl: multi-cycle sequencer stepping each instruction through
// FETCH -> EXEC1 -> EXEC2, holding cpu_pc in reset after core reset, stalling
// on waitrequest / md_busy, and trapping on halt, illegal access or timeout.
//   in : clk, reset_n, waitrequest, pc_i, is_load, is_store, writes_rf, md_busy
//   out: state_o, active, pc_reset_o, pc_wen, ir_wen, mem_read, mem_write,
//        instr_fetch, ld_data_wen, rf_wen, bus_err_o
module cpu_cycle_ctrl
  import cpu_cycle_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 2,
  parameter int MAX_WAIT     = 0
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   waitrequest,
  input  size_t  pc_i,
  input  logic   is_load,
  input  logic   is_store,
  input  logic   writes_rf,
  input  logic   md_busy,
  output state_t state_o,
  output logic   active,
  output logic   pc_reset_o,
  output logic   pc_wen,
  output logic   ir_wen,
  output logic   mem_read,
  output logic   mem_write,
  output logic   instr_fetch,
  output logic   ld_data_wen,
  output logic   rf_wen,
  output logic   bus_err_o
);

  localparam int RW = cnt_width(RESET_CYCLES);

  state_t        state_q;
  state_t        state_n;
  logic [RW-1:0] rst_cnt;
  logic          rst_last;
  logic          bus_err_q;
  logic          halt;
  logic          stall;
  logic          timeout;

  // The edge that ends the RESET_CYCLES-th reset cycle moves to FETCH.
  assign rst_last = (rst_cnt == RW'(RESET_CYCLES - 1));
  assign halt     = (pc_i == HALT_ADDR);

  // A stall is any cycle with a bus strobe up while the bus holds us off.
  // EXEC1 without an access and EXEC2 never strobe, so waitrequest is
  // naturally ignored there.
  assign stall = (mem_read | mem_write) & waitrequest;

  cpu_stall_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_stall_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .stall   (stall),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RESET;
      rst_cnt   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if ((state_q == S_RESET) && !rst_last) begin
        rst_cnt <= rst_cnt + RW'(1);
      end
      // Sticky: only reset_n clears it, and S_ERROR never exits anyway.
      if (state_n == S_ERROR) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  // Next state and strobes decode from the state register plus the current
  // inputs, so an async reset drops every strobe in the same instant.
  always_comb begin
    state_n     = state_q;
    active      = 1'b0;
    pc_reset_o  = 1'b0;
    pc_wen      = 1'b0;
    ir_wen      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    instr_fetch = 1'b0;
    ld_data_wen = 1'b0;
    rf_wen      = 1'b0;

    case (state_q)
      S_RESET: begin
        pc_reset_o = 1'b1;
        if (rst_last) begin
          state_n = S_FETCH;
        end
      end

      S_FETCH: begin
        active = 1'b1;
        if (halt) begin
          // Fetch from the halt address: no bus read is ever issued.
          state_n = S_HALTED;
        end else begin
          mem_read    = 1'b1;
          instr_fetch = 1'b1;
          if (!waitrequest) begin
            ir_wen  = 1'b1;
            state_n = S_EXEC1;
          end else if (timeout) begin
            state_n = S_ERROR;
          end
        end
      end

      S_EXEC1: begin
        active = 1'b1;
        if (is_load && is_store) begin
          state_n = S_ERROR;
        end else if (is_load || is_store) begin
          mem_read  = is_load;
          mem_write = is_store;
          if (!waitrequest) begin
            ld_data_wen = is_load;
            state_n     = S_EXEC2;
          end else if (timeout) begin
            state_n = S_ERROR;
          end
        end else begin
          state_n = S_EXEC2;
        end
      end

      S_EXEC2: begin
        active = 1'b1;
        // The single commit point of an instruction: pc_wen fires exactly
        // once, on the cycle that leaves EXEC2.
        if (!md_busy) begin
          pc_wen  = 1'b1;
          rf_wen  = writes_rf;
          state_n = S_FETCH;
        end
      end

      S_HALTED, S_ERROR: begin
        state_n = state_q;
      end

      default: begin
        // Unused encodings trap rather than wander.
        state_n = S_ERROR;
      end
    endcase
  end

  assign state_o   = state_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_cpu_cycle_ctrl.sv
`timescale 1ns/1ps
module tb_cpu_cycle_ctrl;
  import cpu_cycle_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   reset_n, waitrequest, is_load, is_store, writes_rf, md_busy;
  size_t  pc_i;

  state_t state0, state1;
  logic   active0, pc_reset0, pc_wen0, ir_wen0, mem_read0, mem_write0;
  logic   instr_fetch0, ld_data_wen0, rf_wen0, bus_err0;
  logic   active1, pc_reset1, pc_wen1, ir_wen1, mem_read1, mem_write1;
  logic   instr_fetch1, ld_data_wen1, rf_wen1, bus_err1;
  logic [6:0] strobes0, strobes1;

  assign strobes0 = {pc_wen0, ir_wen0, mem_read0, mem_write0, instr_fetch0, ld_data_wen0, rf_wen0};
  assign strobes1 = {pc_wen1, ir_wen1, mem_read1, mem_write1, instr_fetch1, ld_data_wen1, rf_wen1};

  // dut0: no timeout; dut1: MAX_WAIT=3. Both see the same stimulus.
  cpu_cycle_ctrl #(.RESET_CYCLES(2), .MAX_WAIT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .waitrequest(waitrequest), .pc_i(pc_i),
    .is_load(is_load), .is_store(is_store), .writes_rf(writes_rf), .md_busy(md_busy),
    .state_o(state0), .active(active0), .pc_reset_o(pc_reset0), .pc_wen(pc_wen0),
    .ir_wen(ir_wen0), .mem_read(mem_read0), .mem_write(mem_write0),
    .instr_fetch(instr_fetch0), .ld_data_wen(ld_data_wen0), .rf_wen(rf_wen0),
    .bus_err_o(bus_err0)
  );

  cpu_cycle_ctrl #(.RESET_CYCLES(2), .MAX_WAIT(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .waitrequest(waitrequest), .pc_i(pc_i),
    .is_load(is_load), .is_store(is_store), .writes_rf(writes_rf), .md_busy(md_busy),
    .state_o(state1), .active(active1), .pc_reset_o(pc_reset1), .pc_wen(pc_wen1),
    .ir_wen(ir_wen1), .mem_read(mem_read1), .mem_write(mem_write1),
    .instr_fetch(instr_fetch1), .ld_data_wen(ld_data_wen1), .rf_wen(rf_wen1),
    .bus_err_o(bus_err1)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: one entry per instruction commit expected from dut0.
  typedef struct {
    logic rf;
    int   cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (pc_wen0 === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_pc_wen: pc_wen=1 at cycle %0d, required no commit", cyc);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (rf_wen0 !== mon_e.rf) begin
          errors++;
          $display("FAIL sb_rf_wen: got %b required %b (cycle %0d)", rf_wen0, mon_e.rf, cyc);
        end
        checks++;
        if (cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL sb_pc_wen_cycle: got cycle %0d required %0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ends just after the 2nd edge following release: DUT in its first FETCH cycle.
  task automatic do_reset();
    reset_n = 1'b0; waitrequest = 1'b1; is_load = 1'b0; is_store = 1'b0;
    writes_rf = 1'b0; md_busy = 1'b0; pc_i = 32'hBFC0_0000;
    #1;
    checks++;
    if (state0 !== S_RESET || state1 !== S_RESET || pc_reset0 !== 1'b1 || pc_reset1 !== 1'b1 ||
        active0 !== 1'b0 || active1 !== 1'b0 || strobes0 !== 7'd0 || strobes1 !== 7'd0 ||
        bus_err0 !== 1'b0 || bus_err1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: st=%0d/%0d pcr=%b/%b act=%b/%b strb=%b/%b err=%b/%b required 0/0 1/1 0/0 0/0 0/0",
               state0, state1, pc_reset0, pc_reset1, active0, active1, strobes0, strobes1, bus_err0, bus_err1);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (state0 !== S_RESET || pc_reset0 !== 1'b1 || active0 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold%0d: st=%0d pcr=%b act=%b required st=0 pcr=1 act=0",
                 i, state0, pc_reset0, active0);
      end
      tick();
    end
  endtask

  // Precondition: just after an edge, dut0 in FETCH.
  task automatic run_instr(input size_t pc, input logic ld, input logic st, input logic wr,
                           input int fw, input int ew, input int md,
                           output int rd_cyc, output int ld_cnt, output int pw_cnt, output int pcw_cyc);
    rd_cyc = 0; ld_cnt = 0; pw_cnt = 0; pcw_cyc = -1;
    pc_i = pc; is_load = ld; is_store = st; writes_rf = wr; md_busy = 1'b0;
    for (int i = 0; i <= fw; i++) begin
      waitrequest = (i < fw);
      @(negedge clk);
      checks++;
      if (state0 !== S_FETCH || mem_read0 !== 1'b1 || instr_fetch0 !== 1'b1 ||
          ir_wen0 !== (i == fw) || pc_wen0 !== 1'b0) begin
        errors++;
        $display("FAIL fetch_c%0d: st=%0d rd=%b if=%b ir=%b pcw=%b required st=1 rd=1 if=1 ir=%b pcw=0",
                 i, state0, mem_read0, instr_fetch0, ir_wen0, pc_wen0, (i == fw));
      end
      tick();
    end
    if (ld || st) begin
      for (int i = 0; i <= ew; i++) begin
        waitrequest = (i < ew);
        @(negedge clk);
        checks++;
        if (state0 !== S_EXEC1 || mem_read0 !== ld || mem_write0 !== st || instr_fetch0 !== 1'b0 ||
            ld_data_wen0 !== (ld && i == ew) || ir_wen0 !== 1'b0) begin
          errors++;
          $display("FAIL exec1_c%0d: st=%0d rd=%b wr=%b if=%b ldw=%b required st=2 rd=%b wr=%b if=0 ldw=%b",
                   i, state0, mem_read0, mem_write0, instr_fetch0, ld_data_wen0, ld, st, (ld && i == ew));
        end
        if (mem_read0 === 1'b1) rd_cyc++;
        if (ld_data_wen0 === 1'b1) ld_cnt++;
        tick();
      end
    end else begin
      waitrequest = 1'b1;  // must be ignored without an access
      @(negedge clk);
      checks++;
      if (state0 !== S_EXEC1 || strobes0 !== 7'd0) begin
        errors++;
        $display("FAIL exec1_alu: st=%0d strb=%b required st=2 strb=0", state0, strobes0);
      end
      tick();
    end
    waitrequest = 1'b1;
    for (int i = 0; i <= md; i++) begin
      md_busy = (i < md);
      if (i == md) sb.push_back('{rf: wr, cyc: cyc});
      @(negedge clk);
      checks++;
      if (state0 !== S_EXEC2 || pc_wen0 !== (i == md) || rf_wen0 !== (wr && i == md) ||
          mem_read0 !== 1'b0 || mem_write0 !== 1'b0) begin
        errors++;
        $display("FAIL exec2_c%0d: st=%0d pcw=%b rfw=%b required st=3 pcw=%b rfw=%b",
                 i, state0, pc_wen0, rf_wen0, (i == md), (wr && i == md));
      end
      if (pc_wen0 === 1'b1) begin
        pw_cnt++;
        pcw_cyc = cyc;
      end
      tick();
    end
    md_busy = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (state0 !== S_FETCH || active0 !== 1'b1 || pc_reset0 !== 1'b0 || mem_read0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_to_fetch: st=%0d act=%b pcr=%b rd=%b required st=1 act=1 pcr=0 rd=1",
               state0, active0, pc_reset0, mem_read0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int r, l, p, c1, c2;
    do_reset();
    run_instr(32'hBFC0_0000, 1'b0, 1'b0, 1'b1, 0, 0, 0, r, l, p, c1);
    run_instr(32'hBFC0_0004, 1'b0, 1'b0, 1'b0, 0, 0, 0, r, l, p, c2);
    checks++;
    if (c2 - c1 != 3) begin
      errors++;
      $display("FAIL pc_wen_period: got %0d cycles required 3", c2 - c1);
    end
  endtask

  task automatic test_load_wait();
    int r, l, p, c;
    do_reset();
    run_instr(32'hBFC0_0010, 1'b1, 1'b0, 1'b1, 0, 4, 0, r, l, p, c);
    checks++;
    if (r != 5 || l != 1 || p != 1) begin
      errors++;
      $display("FAIL load_wait: rd_cycles=%0d ld_pulses=%0d pc_pulses=%0d required 5 1 1", r, l, p);
    end
    // Store with a stalled fetch and a stalled write.
    run_instr(32'hBFC0_0014, 1'b0, 1'b1, 1'b0, 2, 2, 0, r, l, p, c);
    checks++;
    if (r != 0 || l != 0 || p != 1) begin
      errors++;
      $display("FAIL store_wait: rd_cycles=%0d ld_pulses=%0d pc_pulses=%0d required 0 0 1", r, l, p);
    end
  endtask

  task automatic test_halt();
    do_reset();
    pc_i = HALT_ADDR; waitrequest = 1'b0;
    @(negedge clk);
    checks++;
    if (state0 !== S_FETCH || mem_read0 !== 1'b0 || ir_wen0 !== 1'b0 || active0 !== 1'b1) begin
      errors++;
      $display("FAIL halt_fetch: st=%0d rd=%b ir=%b act=%b required st=1 rd=0 ir=0 act=1",
               state0, mem_read0, ir_wen0, active0);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      pc_i = 32'hBFC0_0000 + 32'(i * 4);
      waitrequest = i[0];
      @(negedge clk);
      checks++;
      if (state0 !== S_HALTED || active0 !== 1'b0 || strobes0 !== 7'd0) begin
        errors++;
        $display("FAIL halted_c%0d: st=%0d act=%b strb=%b required st=4 act=0 strb=0",
                 i, state0, active0, strobes0);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    do_reset();  // waitrequest stuck high in FETCH from here on
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (state1 !== S_FETCH || mem_read1 !== 1'b1 || bus_err1 !== 1'b0) begin
        errors++;
        $display("FAIL timeout_stall_c%0d: st=%0d rd=%b err=%b required st=1 rd=1 err=0",
                 i, state1, mem_read1, bus_err1);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state1 !== S_ERROR || bus_err1 !== 1'b1 || active1 !== 1'b0 || strobes1 !== 7'd0) begin
        errors++;
        $display("FAIL timeout_error_c%0d: st=%0d err=%b act=%b strb=%b required st=5 err=1 act=0 strb=0",
                 i, state1, bus_err1, active1, strobes1);
      end
      checks++;
      if (state0 !== S_FETCH || bus_err0 !== 1'b0) begin
        errors++;
        $display("FAIL no_timeout_c%0d: st=%0d err=%b required st=1 err=0", i, state0, bus_err0);
      end
      tick();
    end
    do_reset();  // checks bus_err cleared by reset
  endtask

  task automatic test_illegal();
    do_reset();
    pc_i = 32'hBFC0_0020; waitrequest = 1'b0; is_load = 1'b1; is_store = 1'b1;
    tick();  // fetch completes
    @(negedge clk);
    checks++;
    if (state0 !== S_EXEC1 || mem_read0 !== 1'b0 || mem_write0 !== 1'b0) begin
      errors++;
      $display("FAIL illegal_exec1: st=%0d rd=%b wr=%b required st=2 rd=0 wr=0", state0, mem_read0, mem_write0);
    end
    tick();
    @(negedge clk);
    checks++;
    if (state0 !== S_ERROR || bus_err0 !== 1'b1 || active0 !== 1'b0) begin
      errors++;
      $display("FAIL illegal_error: st=%0d err=%b act=%b required st=5 err=1 act=0", state0, bus_err0, active0);
    end
    is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic test_md_stall();
    int r, l, p, c, start;
    do_reset();
    start = cyc;
    run_instr(32'hBFC0_0030, 1'b0, 1'b0, 1'b1, 0, 0, 5, r, l, p, c);
    checks++;
    if (c - start != 7 || p != 1) begin
      errors++;
      $display("FAIL md_delay: pc_wen at +%0d pulses=%0d required +7 pulses=1", c - start, p);
    end
    // Reset in the middle of an md_busy stall: nothing may commit.
    do_reset();
    pc_i = 32'hBFC0_0040; waitrequest = 1'b0; writes_rf = 1'b1;
    tick();
    tick();
    md_busy = 1'b1;
    @(negedge clk);
    checks++;
    if (state0 !== S_EXEC2 || pc_wen0 !== 1'b0) begin
      errors++;
      $display("FAIL md_stall: st=%0d pcw=%b required st=3 pcw=0", state0, pc_wen0);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (state0 !== S_RESET || pc_wen0 !== 1'b0 || rf_wen0 !== 1'b0 || pc_reset0 !== 1'b1 || active0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stall: st=%0d pcw=%b rfw=%b pcr=%b act=%b required st=0 pcw=0 rfw=0 pcr=1 act=0",
               state0, pc_wen0, rf_wen0, pc_reset0, active0);
    end
    md_busy = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
  endtask

  initial begin
    reset_n = 1'b0; waitrequest = 1'b0; is_load = 1'b0; is_store = 1'b0;
    writes_rf = 1'b0; md_busy = 1'b0; pc_i = '0;
    test_reset();
    test_back_to_back();
    test_load_wait();
    test_halt();
    test_timeout();
    test_illegal();
    test_md_stall();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d commits still expected, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
